// File: rtl/zero_cmp_pkg.sv
// Shared definitions for the zero-compare arbiter.
// Holds the FSM state encoding and the compare mode constants.
// Ports: none (package).
package zero_cmp_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic MODE_EQ = 1'b0;
  localparam logic MODE_NE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_CALC = CALC,
    ST_RESP = RESP
  } state_t;

endpackage

// File: rtl/zero_cmp_arbiter_if.sv
// Bundle of both requester handshakes plus the shared result signals.
// master: requester side (drives req/operands/mode, observes grants/results).
// slave : arbiter side.
//   req0/req1   request levels, held until the matching gnt
//   a0/b0/a1/b1 operands, WIDTH bits
//   mode0/mode1 0 = EQ, 1 = NE
//   gnt0/gnt1   one-cycle grant, operands captured that cycle
//   done0/done1 one-cycle result strobe for the owner
//   cond        compare result, valid only with a done strobe
//   busy        high while a compare is in flight
interface zero_cmp_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             mode0;
  logic             gnt0;

  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             mode1;
  logic             gnt1;

  logic             done0;
  logic             done1;
  logic             cond;
  logic             busy;

  modport master (
    output req0, a0, b0, mode0,
    output req1, a1, b1, mode1,
    input  gnt0, gnt1, done0, done1, cond, busy
  );

  modport slave (
    input  req0, a0, b0, mode0,
    input  req1, a1, b1, mode1,
    output gnt0, gnt1, done0, done1, cond, busy
  );

endinterface

// File: rtl/zero_cmp_arbiter_zdet.sv
// Zero detector: zero = 1 when every bit of din is 0.
// Ports:
//   din   in  WIDTH  value to test
//   zero  out 1      all-zero flag
module zero_cmp_arbiter_zdet #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  output logic             zero
);

  assign zero = ~|din;

endmodule

// File: rtl/zero_cmp_arbiter.sv
// Arbitrates one registered compare/zero-detect resource between the
// branch unit (port 0) and the trap/loop-check unit (port 1).
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset
//   bus    slave modport of zero_cmp_arbiter_if (requests, grants, results)
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for a request; grants combinationally here only
// ST_CALC | captured operands go through XOR + zero detect
// ST_RESP | done strobe to the owner, cond driven from the register
module zero_cmp_arbiter
  import zero_cmp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RR_INIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  zero_cmp_arbiter_if.slave  bus
);

  localparam logic PRIO_INIT = (RR_INIT != 0);

  state_t           state;
  logic             prio;
  logic             owner;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mode_q;
  logic             done0_q;
  logic             done1_q;
  logic             cond_q;
  logic             busy_q;

  logic             in_idle;
  logic             gnt0_c;
  logic             gnt1_c;
  logic             zero;

  // On contention the index equal to prio wins; a lone request always wins.
  assign in_idle = (state == ST_IDLE);
  assign gnt0_c  = in_idle && bus.req0 && (!bus.req1 || (prio == 1'b0));
  assign gnt1_c  = in_idle && bus.req1 && (!bus.req0 || (prio == 1'b1));

  zero_cmp_arbiter_zdet #(
    .WIDTH (WIDTH)
  ) u_zdet (
    .din  (op_a ^ op_b),
    .zero (zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      prio    <= PRIO_INIT;
      owner   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      mode_q  <= MODE_EQ;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      cond_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt0_c || gnt1_c) begin
            op_a   <= gnt1_c ? bus.a1    : bus.a0;
            op_b   <= gnt1_c ? bus.b1    : bus.b0;
            mode_q <= gnt1_c ? bus.mode1 : bus.mode0;
            owner  <= gnt1_c;
            // Priority passes to the index that just lost (or did not ask).
            prio   <= ~gnt1_c;
            busy_q <= 1'b1;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          cond_q  <= (mode_q == MODE_NE) ? ~zero : zero;
          done0_q <= ~owner;
          done1_q <= owner;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          cond_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          cond_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0  = gnt0_c;
  assign bus.gnt1  = gnt1_c;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.cond  = cond_q;
  assign bus.busy  = busy_q;

endmodule

// File: doc/zero_cmp_arbiter.md
Name: zero_cmp_arbiter

Overview:
- Shares one registered 32-bit compare/zero-detect resource between two requesters: port 0 is the branch unit and port 1 is the trap/loop-check unit.
- Each request supplies two operands and a mode (EQ or NE). The block forms A XOR B, zero-detects the result, and returns a 1-bit condition to the granted requester.
- The block sits beside the ALU. It removes the need for a second zero-detector when the multi-cycle core variant has two units that need compares.

Parameters:
- WIDTH, 32, operand width in bits. Must be at least 1.
- RR_INIT, 0, requester index that holds priority after reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req0  in  1  requester 0 request, level; held until gnt0
- a0  in  WIDTH  requester 0 operand A
- b0  in  WIDTH  requester 0 operand B
- mode0  in  1  requester 0 mode: 0 = EQ (cond = A==B), 1 = NE
- gnt0  out  1  one-cycle pulse; a0/b0/mode0 captured this cycle
- req1, a1, b1, mode1, gnt1  same as above for requester 1
- done0  out  1  one-cycle pulse; result valid for requester 0
- done1  out  1  one-cycle pulse; result valid for requester 1
- cond  out  1  compare result; meaningful only while done0 or done1 = 1
- busy  out  1  high in CALC and RESP

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, prio=RR_INIT, and gnt0/gnt1/done0/done1/cond/busy=0. Reset mid-operation aborts the operation: no done pulse is issued and captured operands are discarded.
- FSM states are IDLE, CALC and RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the index equal to prio.
  - A grant is combinational in that cycle: gntX=1 and opA/opB/mode/owner are registered at the edge, then next state is CALC.
  - prio then flips to the non-granted index. prio changes only on a grant.
  - With no req, stay in IDLE.
- CALC:
  - Register z = (opA XOR opB == 0).
  - Register cond_r = z XOR mode.
  - Next state is RESP.
- RESP:
  - doneX=1 for owner only, and cond=cond_r.
  - Next state is IDLE. No grant is issued in RESP.
- Latency: grant at cycle N, done at cycle N+2. Maximum throughput is one compare per 3 cycles.
- gnt and done are never high for both requesters in the same cycle.
- gnt is never asserted outside IDLE.
- A req held while busy waits with no loss. A req dropped before its grant is simply never serviced.
- The requester must deassert req in the cycle after gnt, or it will be re-arbitrated as a new request.
- Operand changes after gnt do not affect the in-flight result.
- cond is held 0 outside RESP.
- All outputs except gnt0/gnt1 are registered or state-decoded; gnt depends on req and state only.
- Boundary cases:
  - All-ones vs all-ones in EQ → cond=1.
  - 0 vs 0x8000_0000 → differs in MSB only → cond=0 in EQ.
  - WIDTH=1 must function.

Decomposition:
- Shared package zero_cmp_pkg holds:
  - the state encoding localparams (IDLE=2'd0, CALC=2'd1, RESP=2'd2);
  - the mode constants (MODE_EQ=1'b0, MODE_NE=1'b1).
- One sub-module: the existing 32-bit zero-detector (output 1 when its input is all-zero). It is instantiated once on opA XOR opB. The arbiter is the only instance of it in this path.

Test Plan:
- Single request: req0=1, a0=b0=0x1234_5678, mode0=EQ → gnt0 at N; done0=1 and cond=1 at N+2; done1 stays 0.
- NE mode: req1=1, a1=0x0000_0000, b1=0x8000_0000, mode1=NE → gnt1 at N; done1=1 and cond=1 at N+2. Repeat with mode1=EQ → cond=0.
- Simultaneous requests after reset with RR_INIT=0:
  - req0=req1=1 held → gnt0 at cycle 1, done0 at cycle 3, gnt1 at cycle 4, done1 at cycle 6, gnt0 at cycle 7.
  - Check strict alternation and that both gnt are never high in the same cycle.
- Operand change after grant: a0=b0=0xFFFF_FFFF, EQ, granted; a0 changes to 0 on the next cycle → cond still 1 at done0.
- Reset mid-operation: grant at N, rst_n=0 at N+1 → no done pulse, busy=0 and state=IDLE at N+2, prio=RR_INIT. A new req0 is then granted normally.
- Idle and busy hold:
  - No req for 10 cycles → all outputs 0.
  - req1 asserted during CALC of a req0 operation → gnt1 only once the FSM is back in IDLE (N+3).
